// File: rtl/store_narrower.sv
// Store narrowing FIFO: lane-replicates byte/half/word stores into word-aligned memory writes.
// Optional STORE_ALIGN_CHECK_EN drops misaligned half/word requests and pulses misalign instead.
module store_narrower #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_addr,
  input  logic [31:0]              in_data,
  input  logic [1:0]               in_size,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("store_narrower: DEPTH must be a power of two of at least 2");
    end
  endgenerate

  logic [29:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [3:0]    be_mem   [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   nar_wdata;
  logic [3:0]    nar_be;

  assign in_ready  = (count < FULL);
  assign accept    = in_valid && in_ready;
  assign mem_valid = (count != '0);
  assign pop       = mem_valid && mem_ready;

  always_comb begin
    nar_wdata = in_data;
    nar_be    = 4'b1111;
    case (in_size)
      2'b00: begin
        nar_wdata = {4{in_data[7:0]}};
        nar_be    = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        nar_wdata = {2{in_data[15:0]}};
        nar_be    = in_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        nar_wdata = in_data;
        nar_be    = 4'b1111;
      end
    endcase
  end

`ifdef STORE_ALIGN_CHECK_EN
  logic bad_align;

  // Misaligned requests are still handshaken but never reach the FIFO.
  assign bad_align = ((in_size == 2'b01) && in_addr[0]) ||
                     (in_size[1] && (in_addr[1:0] != 2'b00));
  assign push      = accept && !bad_align;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign <= 1'b0;
    end else begin
      misalign <= accept && bad_align;
    end
  end
`else
  assign push     = accept;
  assign misalign = 1'b0;
`endif

  // Entry payload needs no reset: outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= in_addr[31:2];
      data_mem[tail] <= nar_wdata;
      be_mem[tail]   <= nar_be;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign mem_addr  = mem_valid ? {addr_mem[head], 2'b00} : 32'h0;
  assign mem_wdata = mem_valid ? data_mem[head] : 32'h0;
  assign mem_be    = mem_valid ? be_mem[head] : 4'h0;

endmodule

// File: tb/tb_store_narrower.sv
// Self-checking bench for store_narrower: vector table, scoreboard monitor and multi-cycle sequences.
// Honours STORE_ALIGN_CHECK_EN in the same way as the design.
module tb_store_narrower;

  localparam int DEPTH = 4;
`ifdef STORE_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [$clog2(DEPTH):0] count;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic [3:0]  ebe;
    bit          mis;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[11];
  bit   pend_mis = 1'b0;

  store_narrower #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_size(in_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .count(count), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit isMis(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'b00) return 1'b0;
    if (s == 2'b01) return a[0];
    return (a[1:0] != 2'b00);
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    exp_t e;
    e.addr = {a[31:2], 2'b00};
    if (s == 2'b00) begin
      e.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
      e.be    = {a[1:0] == 2'd3, a[1:0] == 2'd2, a[1:0] == 2'd1, a[1:0] == 2'd0};
    end else if (s == 2'b01) begin
      e.wdata = {d[15:0], d[15:0]};
      e.be    = a[1] ? 4'b1100 : 4'b0011;
    end else begin
      e.wdata = d;
      e.be    = 4'b1111;
    end
    return e;
  endfunction

  // Scoreboard monitor: compares occupancy, popped entries and the misalign pulse each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
      pend_mis = 1'b0;
    end else begin
      checkOutput("count_vs_model", 32'(count), 32'(sb.size()));
      checkOutput("valid_vs_model", 32'(mem_valid), 32'(sb.size() != 0));
      checkOutput("misalign_vs_model", 32'(misalign), 32'(pend_mis));
      if (mem_valid && mem_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_underflow: got an unexpected pop of addr 0x%08h, expected none", mem_addr);
        end else begin
          e = sb.pop_front();
          checkOutput("sb_addr", mem_addr, e.addr);
          checkOutput("sb_wdata", mem_wdata, e.wdata);
          checkOutput("sb_be", 32'(mem_be), 32'(e.be));
        end
      end
      pend_mis = ALIGN_EN && in_valid && in_ready && isMis(in_addr, in_size);
      if (in_valid && in_ready && !(ALIGN_EN && isMis(in_addr, in_size))) begin
        sb.push_back(model(in_addr, in_data, in_size));
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int  n = 0;
    bit  done = 1'b0;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
    in_valid = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no acceptance for addr 0x%08h, expected one within 20 cycles", a);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((count != 0 || sb.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_count", 32'(count), 32'h0);
    checkOutput("drain_sb", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'h0000_1003, 32'h0000_00A5, 2'b00, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000, 1'b0};
    vecs[1]  = '{32'h0000_2002, 32'h1234_BEEF, 2'b01, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100, 1'b0};
    vecs[2]  = '{32'h0000_4000, 32'hFFFF_FF3C, 2'b00, 32'h0000_4000, 32'h3C3C_3C3C, 4'b0001, 1'b0};
    vecs[3]  = '{32'h0000_4001, 32'h0000_0077, 2'b00, 32'h0000_4000, 32'h7777_7777, 4'b0010, 1'b0};
    vecs[4]  = '{32'h0000_4002, 32'h0000_005A, 2'b00, 32'h0000_4000, 32'h5A5A_5A5A, 4'b0100, 1'b0};
    vecs[5]  = '{32'h0000_5000, 32'hAAAA_CAFE, 2'b01, 32'h0000_5000, 32'hCAFE_CAFE, 4'b0011, 1'b0};
    vecs[6]  = '{32'h0000_6004, 32'hDEAD_BEEF, 2'b10, 32'h0000_6004, 32'hDEAD_BEEF, 4'b1111, 1'b0};
    vecs[7]  = '{32'h0000_7008, 32'h0102_0304, 2'b11, 32'h0000_7008, 32'h0102_0304, 4'b1111, 1'b0};
    vecs[8]  = '{32'h0000_3001, 32'h89AB_CDEF, 2'b10, 32'h0000_3000, 32'h89AB_CDEF, 4'b1111, 1'b1};
    vecs[9]  = '{32'h0000_8003, 32'h0000_4321, 2'b01, 32'h0000_8000, 32'h4321_4321, 4'b1100, 1'b1};
    vecs[10] = '{32'h0000_8001, 32'h0000_9876, 2'b01, 32'h0000_8000, 32'h9876_9876, 4'b0011, 1'b1};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_addr   = 32'h0;
    in_data   = 32'h0;
    in_size   = 2'b00;
    mem_ready = 1'b1;
    #3;
    checkOutput("rst_count", 32'(count), 32'h0);
    checkOutput("rst_mem_valid", 32'(mem_valid), 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_misalign", 32'(misalign), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Single requests drained immediately: one cycle of latency, then empty.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].size);
      @(negedge clk);
      if (ALIGN_EN && vecs[i].mis) begin
        checkOutput($sformatf("vec%0d_misalign", i), 32'(misalign), 32'h1);
        checkOutput($sformatf("vec%0d_not_queued", i), 32'(count), 32'h0);
      end else begin
        checkOutput($sformatf("vec%0d_valid", i), 32'(mem_valid), 32'h1);
        checkOutput($sformatf("vec%0d_addr", i), mem_addr, vecs[i].eaddr);
        checkOutput($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].ewdata);
        checkOutput($sformatf("vec%0d_be", i), 32'(mem_be), 32'(vecs[i].ebe));
        checkOutput($sformatf("vec%0d_misalign", i), 32'(misalign), 32'h0);
      end
      @(negedge clk);
      checkOutput($sformatf("vec%0d_empty", i), 32'(mem_valid), 32'h0);
      checkOutput($sformatf("vec%0d_empty_addr", i), mem_addr, 32'h0);
      checkOutput($sformatf("vec%0d_mis_gone", i), 32'(misalign), 32'h0);
      @(posedge clk);
      #1;
    end

    // Fill to full with memory stalled, hold a fifth request, then drain.
    mem_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(32'h0000_9000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 2'b10);
    end
    @(negedge clk);
    checkOutput("full_count", 32'(count), 32'(DEPTH));
    checkOutput("full_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    in_addr  = 32'h0000_9010;
    in_data  = 32'h5555_0005;
    in_size  = 2'b10;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold_in_ready", 32'(in_ready), 32'h0);
      checkOutput("hold_count", 32'(count), 32'(DEPTH));
      checkOutput("hold_addr", mem_addr, 32'h0000_9000);
      checkOutput("hold_wdata", mem_wdata, 32'h1111_0000);
    end
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("no_comb_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("ready_after_pop", 32'(in_ready), 32'h1);
    checkOutput("count_after_pop", 32'(count), 32'(DEPTH - 1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("count_push_pop", 32'(count), 32'(DEPTH - 1));
    waitDrain();

    // Two buffered, then simultaneous push/pop across pointer wrap.
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    applyStimulus(32'h0000_A000, 32'h0000_00C1, 2'b00);
    applyStimulus(32'h0000_A102, 32'h0000_D2D2, 2'b01);
    @(negedge clk);
    checkOutput("two_count", 32'(count), 32'h2);
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_addr = 32'h0000_B000 + 32'(i * 5);
      in_data = 32'h7000_0000 + 32'(i * 32'h0101_0101);
      in_size = 2'(i % 3);
      if (ALIGN_EN && isMis(in_addr, in_size)) in_size = 2'b00;
      @(negedge clk);
      checkOutput($sformatf("pp%0d_count", i), 32'(count), 32'h2);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    waitDrain();

    // Reset with three entries buffered discards them immediately.
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h0000_C000 + 32'(i * 4), 32'hC0C0_0000 + 32'(i), 2'b10);
    end
    @(negedge clk);
    checkOutput("pre_rst_count", 32'(count), 32'h3);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("arst_mem_valid", 32'(mem_valid), 32'h0);
    checkOutput("arst_count", 32'(count), 32'h0);
    checkOutput("arst_in_ready", 32'(in_ready), 32'h1);
    checkOutput("arst_wdata", mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_rst_idle", 32'(mem_valid), 32'h0);
    end
    @(posedge clk);
    #1;
    applyStimulus(32'h0000_D001, 32'h0000_00E7, 2'b00);
    @(negedge clk);
    checkOutput("post_rst_addr", mem_addr, 32'h0000_D000);
    checkOutput("post_rst_wdata", mem_wdata, 32'hE7E7_E7E7);
    checkOutput("post_rst_be", 32'(mem_be), 32'h2);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
